// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: load-use stalls,
// multi-cycle taken-branch flushes, memory-wait freeze, timeout flag and event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  idex_write_o,
  output logic                  exmem_write_o,
  output logic                  memwb_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX   = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic freeze, lu, fl;

  // Hazard decode, FSM next state and same-cycle pipeline controls
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_write_o  = 1'b0;
    exmem_write_o = 1'b0;
    memwb_write_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    stall_o       = 1'b0;
    flush_o       = 1'b0;

    freeze = mem_req_i & ~mem_ready_i;
    lu     = ex_mem_read_i & (ex_rd_i != '0) &
             ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
              (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
    fl     = ex_branch_taken_i | (state_q == ST_FLUSH);

    if (rst_n) begin
      if (freeze) begin
        stall_o = 1'b1;
      end else if (fl) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_write_o  = 1'b1;
        exmem_write_o = 1'b1;
        memwb_write_o = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        flush_o       = 1'b1;
      end else if (lu) begin
        idex_write_o  = 1'b1;
        exmem_write_o = 1'b1;
        memwb_write_o = 1'b1;
        idex_flush_o  = 1'b1;
        stall_o       = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_write_o  = 1'b1;
        exmem_write_o = 1'b1;
        memwb_write_o = 1'b1;
      end
    end

    // Flush countdown only advances on non-frozen cycles; a new taken branch restarts it
    if (!freeze) begin
      if (ex_branch_taken_i) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end else if (state_q == ST_FLUSH) begin
        fcnt_d = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // Memory wait timeout and saturating event counters
  always_comb begin
    wcnt_d      = '0;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze) begin
      wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
      if (wcnt_d == WCNT_MAX) begin
        mem_err_d = 1'b1;
      end
    end
    if (stall_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_o && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      wcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err_o     = mem_err_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
